apb_mem_slave: RTL and testbench
================================

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter: WAIT_STATES, default 1, number of PREADY-low cycles inserted in each ACCESS phase (range 0..15).
REQ-002 SHALL have parameter: MEM_INIT_FILE, default "", optional hex image loaded at elaboration; empty means memory powers up as X.
REQ-003 SHALL have port: sysclk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: PSEL  input  1  slave select.
REQ-006 SHALL have port: PENABLE  input  1  access-phase strobe.
REQ-007 SHALL have port: PWRITE  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: PADDR  input  16  byte address into 64 KiB Pep9 memory.
REQ-009 SHALL have port: PWDATA  input  8  write data.
REQ-010 SHALL have port: PRDATA  output  8  read data, valid only while PREADY=1 on a read.
REQ-011 SHALL have port: PREADY  output  1  transfer completion.
REQ-012 SHALL have port: PSLVERR  output  1  error response, valid only while PREADY=1.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-014 SHALL go IDLE->SETUP when PSEL=1 and PENABLE=0; PSEL=1 with PENABLE=1 from IDLE is a protocol violation: stay IDLE, no memory effect.
REQ-015 SHALL go SETUP->ACCESS on the next edge, registering PADDR, PWRITE, PWDATA and launching the memory read (1-cycle sync read).
REQ-016 SHALL, in ACCESS, hold PREADY=0 for exactly WAIT_STATES cycles via a down-counter loaded at SETUP, then drive PREADY=1 for exactly one cycle.
REQ-017 SHALL, with WAIT_STATES=0, assert PREADY in the first ACCESS cycle (two-cycle transfer).
REQ-018 SHALL commit a write to memory on the edge ending the PREADY=1 cycle, and not earlier.
REQ-019 SHALL present read data on PRDATA in the PREADY=1 cycle and hold the last read value otherwise.
REQ-020 SHALL, after completion, go to SETUP if PSEL=1 and PENABLE=0 (back-to-back), else IDLE.
REQ-021 SHALL abort to IDLE without a memory write if PSEL drops during ACCESS before completion; PREADY stays 0.
REQ-022 SHALL ignore changes to PADDR/PWRITE/PWDATA during ACCESS (registered copies are used).
REQ-023 SHALL drive PREADY=0 and PSLVERR=0 whenever not completing a transfer.
REQ-024 SHALL wrap no addresses: all 16-bit addresses 16'h0000..16'hFFFF map to distinct bytes.

Reset
REQ-025 SHALL, on reset assertion at any time (including mid-transfer), force IDLE, PREADY=0, PSLVERR=0, PRDATA=8'h00 and the wait counter to 0 asynchronously.
REQ-026 SHALL NOT clear or alter memory contents on reset; an in-flight write is dropped.

Configuration
REQ-027 SHALL, when APB_SLV_ROM_PROTECT_EN is defined, treat addresses >= ROM_BASE (16'hFC00) as read-only: a write there completes normally in time with PSLVERR=1 and no memory change.
REQ-028 SHALL, without APB_SLV_ROM_PROTECT_EN, tie PSLVERR to 0 and accept writes to every address.

Structure
REQ-029 SHALL take the state enum, ADDR_W=16, DATA_W=8 and ROM_BASE from shared package apb_pkg.
REQ-030 SHALL instantiate one sub-module apb_mem_array (64K x 8, synchronous read, single write port) holding the storage; FSM, counter and error logic stay in apb_mem_slave.

Verification
REQ-031 Write 8'h11 to 16'h0405 then read 16'h0405, WAIT_STATES=1 -> each transfer 3 cycles, PREADY high one cycle, PRDATA=8'h11.
REQ-032 Back-to-back writes 16'h0406=8'hAB, 16'h0407=8'hCD with WAIT_STATES=0, then reads in order 0407,0406 -> no IDLE gap, PRDATA 8'hCD then 8'hAB.
REQ-033 Write 8'h55 to 16'h0123, deassert PSEL in ACCESS before PREADY (WAIT_STATES=3), then read 16'h0123 -> old value returned, no PREADY during aborted transfer.
REQ-034 Assert reset mid-ACCESS of a write to 16'h0010 -> PREADY/PSLVERR/PRDATA 0 immediately, state IDLE, 16'h0010 unchanged, previously written bytes intact.
REQ-035 With APB_SLV_ROM_PROTECT_EN, write 8'hFF to 16'hFC00 then read -> write completes with PSLVERR=1, read returns original byte with PSLVERR=0; without macro same write succeeds, PSLVERR=0.
REQ-036 Write i[7:0] to every address 0..16'hFFFF then read all -> every byte equals its address LSB.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and sizes for the APB byte-memory slave.
// Address width, data width, ROM window base and FSM state encoding.
package apb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] ROM_BASE = 16'hFC00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic logic is_rom(input logic [ADDR_W-1:0] a);
    return a >= ROM_BASE;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// 64K x 8 storage: one synchronous read port, one write port.
// Contents are never reset.
module apb_mem_array
  import apb_pkg::*;
#(
  parameter string MEM_INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rd_data;

  // Read data is held between enables so it stays stable across wait states.
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en)
      r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave fronting 64 KiB of byte memory with programmable wait states.
// Define APB_SLV_ROM_PROTECT_EN to make addresses >= ROM_BASE read-only.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int    WAIT_STATES   = 1,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef APB_SLV_ROM_PROTECT_EN
  localparam logic ROM_EN = 1'b1;
`else
  localparam logic ROM_EN = 1'b0;
`endif

  apb_state_e        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_prdata;

  logic              w_done;
  logic              w_rd_en;
  logic              w_we;
  logic              w_rom;
  logic [DATA_W-1:0] w_mem_q;

  assign w_done  = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_rd_en = (r_state == SETUP);
  assign w_we    = w_done && r_write && !r_err;
  assign w_rom   = ROM_EN && PWRITE && is_rom(PADDR);

  assign PREADY  = w_done;
  assign PSLVERR = w_done && r_err;
  assign PRDATA  = (w_done && !r_write) ? w_mem_q : r_prdata;

  apb_mem_array #(
    .MEM_INIT_FILE(MEM_INIT_FILE)
  ) u_mem (
    .clk       (sysclk),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (PADDR),
    .o_rd_data (w_mem_q),
    .i_we      (w_we),
    .i_wr_addr (r_addr),
    .i_wr_data (r_wdata)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_prdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (PSEL && !PENABLE)
            r_state <= SETUP;
        end
        SETUP: begin
          r_state <= ACCESS;
          r_addr  <= PADDR;
          r_write <= PWRITE;
          r_wdata <= PWDATA;
          r_err   <= w_rom;
          r_cnt   <= WS;
        end
        ACCESS: begin
          if (r_cnt != 4'd0) begin
            if (!PSEL) begin
              r_state <= IDLE;
              r_cnt   <= 4'd0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end else begin
            if (!r_write)
              r_prdata <= w_mem_q;
            r_state <= (PSEL && !PENABLE) ? SETUP : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench: three slaves (0, 1, 3 wait states) on one bus,
// checked against a sparse byte-memory reference model.
module tb_apb_mem_slave;

`ifdef APB_SLV_ROM_PROTECT_EN
  localparam bit ROM_EN = 1'b1;
`else
  localparam bit ROM_EN = 1'b0;
`endif

  logic            sysclk = 1'b0;
  logic            reset;
  logic [2:0]      psel;
  logic            PENABLE;
  logic            PWRITE;
  logic [15:0]     PADDR;
  logic [7:0]      PWDATA;
  logic [2:0][7:0] prd;
  logic [2:0]      rdy;
  logic [2:0]      slverr;

  int tests = 0;
  int fails = 0;
  logic [7:0] model [int];

  always #5 sysclk = ~sysclk;

  apb_mem_slave #(.WAIT_STATES(0)) u0 (
    .sysclk(sysclk), .reset(reset), .PSEL(psel[0]),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(prd[0]), .PREADY(rdy[0]),
    .PSLVERR(slverr[0])
  );
  apb_mem_slave #(.WAIT_STATES(1)) u1 (
    .sysclk(sysclk), .reset(reset), .PSEL(psel[1]),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(prd[1]), .PREADY(rdy[1]),
    .PSLVERR(slverr[1])
  );
  apb_mem_slave #(.WAIT_STATES(3)) u2 (
    .sysclk(sysclk), .reset(reset), .PSEL(psel[2]),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(prd[2]), .PREADY(rdy[2]),
    .PSLVERR(slverr[2])
  );

  function automatic int ws(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  // Bus-level transfer length: one slave SETUP cycle plus waits plus ready.
  function automatic int exp_cyc(input int i);
    return ws(i) + 2;
  endfunction

  function automatic int key(input int i, input logic [15:0] a);
    return i * 65536 + int'(a);
  endfunction

  function automatic bit exp_err(input logic wr, input logic [15:0] a);
    return ROM_EN && wr && (a >= 16'hFC00);
  endfunction

  task automatic mdl_write(input int i, input logic [15:0] a,
                           input logic [7:0] d);
    if (!exp_err(1'b1, a))
      model[key(i, a)] = d;
  endtask

  // Standard APB master: setup cycle, then access until PREADY.
  task automatic xfer(input int i, input logic wr, input logic [15:0] a,
                      input logic [7:0] d, input bit scramble,
                      output logic [7:0] rd, output logic er,
                      output int cyc);
    psel    = 3'b000;
    psel[i] = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = a;
    PWDATA  = d;
    rd  = 8'h00;
    er  = 1'b0;
    cyc = 0;
    @(posedge sysclk); #1;
    PENABLE = 1'b1;
    forever begin
      @(negedge sysclk);
      cyc++;
      if (rdy[i]) begin
        rd = prd[i];
        er = slverr[i];
        break;
      end
      if (cyc > 40) break;
      @(posedge sysclk); #1;
      if (scramble) begin
        PADDR  = 16'($urandom);
        PWDATA = 8'($urandom);
        PWRITE = 1'($urandom);
      end
    end
    @(posedge sysclk); #1;
    psel    = 3'b000;
    PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; psel = 3'b000; PENABLE = 1'b0;
    PWRITE = 1'b0; PADDR = 16'h0; PWDATA = 8'h0;
    #1;
    tests++;
    if (rdy !== 3'b000) begin
      fails++;
      $display("FAIL reset_pready: got %b want 000", rdy);
    end
    tests++;
    if (slverr !== 3'b000) begin
      fails++;
      $display("FAIL reset_pslverr: got %b want 000", slverr);
    end
    tests++;
    if (prd !== 24'h0) begin
      fails++;
      $display("FAIL reset_prdata: got %h want 000000", prd);
    end
    repeat (2) @(posedge sysclk);
    #1 reset = 1'b0;
    @(posedge sysclk); #1;
  endtask

  task automatic test_write_read();
    logic [7:0] rd; logic er; int c;
    xfer(1, 1'b1, 16'h0405, 8'h11, 1'b0, rd, er, c);
    mdl_write(1, 16'h0405, 8'h11);
    tests++;
    if (c != 3 || er !== 1'b0) begin
      fails++;
      $display("FAIL wr_0405: cycles %0d err %b want 3 0", c, er);
    end
    xfer(1, 1'b0, 16'h0405, 8'h00, 1'b0, rd, er, c);
    tests++;
    if (c != 3 || rd !== 8'h11 || er !== 1'b0) begin
      fails++;
      $display("FAIL rd_0405: cycles %0d data %h err %b want 3 11 0",
               c, rd, er);
    end
    @(negedge sysclk);
    tests++;
    if (prd[1] !== 8'h11 || rdy[1] !== 1'b0) begin
      fails++;
      $display("FAIL prdata_hold: data %h ready %b want 11 0",
               prd[1], rdy[1]);
    end
    @(posedge sysclk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic er; int c;
    xfer(0, 1'b1, 16'h0406, 8'hAB, 1'b0, rd, er, c);
    mdl_write(0, 16'h0406, 8'hAB);
    tests++;
    if (c != 2) begin
      fails++;
      $display("FAIL b2b_wr0406: cycles %0d want 2", c);
    end
    xfer(0, 1'b1, 16'h0407, 8'hCD, 1'b0, rd, er, c);
    mdl_write(0, 16'h0407, 8'hCD);
    tests++;
    if (c != 2) begin
      fails++;
      $display("FAIL b2b_wr0407: cycles %0d want 2", c);
    end
    xfer(0, 1'b0, 16'h0407, 8'h00, 1'b0, rd, er, c);
    tests++;
    if (c != 2 || rd !== 8'hCD) begin
      fails++;
      $display("FAIL b2b_rd0407: cycles %0d data %h want 2 cd", c, rd);
    end
    xfer(0, 1'b0, 16'h0406, 8'h00, 1'b0, rd, er, c);
    tests++;
    if (c != 2 || rd !== 8'hAB) begin
      fails++;
      $display("FAIL b2b_rd0406: cycles %0d data %h want 2 ab", c, rd);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic er; int c; bit seen;
    xfer(2, 1'b1, 16'h0123, 8'h77, 1'b0, rd, er, c);
    mdl_write(2, 16'h0123, 8'h77);
    psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 16'h0123; PWDATA = 8'h55;
    @(posedge sysclk); #1;
    PENABLE = 1'b1;
    seen = 0;
    repeat (2) begin
      @(negedge sysclk);
      if (rdy[2]) seen = 1;
      @(posedge sysclk); #1;
    end
    psel = 3'b000; PENABLE = 1'b0;
    repeat (5) begin
      @(negedge sysclk);
      if (rdy[2]) seen = 1;
    end
    @(posedge sysclk); #1;
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL abort_pready: got 1 want 0");
    end
    xfer(2, 1'b0, 16'h0123, 8'h00, 1'b0, rd, er, c);
    tests++;
    if (c != 5 || rd !== 8'h77) begin
      fails++;
      $display("FAIL abort_rd0123: cycles %0d data %h want 5 77", c, rd);
    end
  endtask

  task automatic test_protocol_violation();
    logic [7:0] rd; logic er; int c; bit seen;
    psel = 3'b010; PENABLE = 1'b1; PWRITE = 1'b1;
    PADDR = 16'h0405; PWDATA = 8'hEE;
    seen = 0;
    repeat (4) begin
      @(negedge sysclk);
      if (rdy[1]) seen = 1;
    end
    @(posedge sysclk); #1;
    psel = 3'b000; PENABLE = 1'b0;
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL violation_pready: got 1 want 0");
    end
    xfer(1, 1'b0, 16'h0405, 8'h00, 1'b0, rd, er, c);
    tests++;
    if (rd !== 8'h11) begin
      fails++;
      $display("FAIL violation_rd0405: data %h want 11", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic er; int c;
    xfer(2, 1'b1, 16'h0010, 8'h3C, 1'b0, rd, er, c);
    mdl_write(2, 16'h0010, 8'h3C);
    psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 16'h0010; PWDATA = 8'hC3;
    @(posedge sysclk); #1;
    PENABLE = 1'b1;
    repeat (5) @(negedge sysclk);
    tests++;
    if (rdy[2] !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre_ready: got %b want 1", rdy[2]);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (rdy !== 3'b000 || slverr !== 3'b000 || prd !== 24'h0) begin
      fails++;
      $display("FAIL midrst_outputs: ready %b err %b data %h want 0",
               rdy, slverr, prd);
    end
    @(posedge sysclk); #1;
    reset = 1'b0; psel = 3'b000; PENABLE = 1'b0;
    xfer(2, 1'b0, 16'h0010, 8'h00, 1'b0, rd, er, c);
    tests++;
    if (c != 5 || rd !== 8'h3C) begin
      fails++;
      $display("FAIL midrst_rd0010: cycles %0d data %h want 5 3c", c, rd);
    end
    xfer(1, 1'b0, 16'h0405, 8'h00, 1'b0, rd, er, c);
    tests++;
    if (rd !== 8'h11) begin
      fails++;
      $display("FAIL midrst_rd0405: data %h want 11", rd);
    end
    xfer(0, 1'b0, 16'h0407, 8'h00, 1'b0, rd, er, c);
    tests++;
    if (rd !== 8'hCD) begin
      fails++;
      $display("FAIL midrst_rd0407: data %h want cd", rd);
    end
  endtask

  task automatic test_rom();
    logic [7:0] rd; logic er; int c;
    logic [15:0] al [3];
    al[0] = 16'hFBFF; al[1] = 16'hFC00; al[2] = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      xfer(1, 1'b1, al[k], 8'hFF - 8'(k), 1'b0, rd, er, c);
      tests++;
      if (c != 3 || er !== exp_err(1'b1, al[k])) begin
        fails++;
        $display("FAIL rom_wr_%h: cycles %0d err %b want 3 %b",
                 al[k], c, er, exp_err(1'b1, al[k]));
      end
      mdl_write(1, al[k], 8'hFF - 8'(k));
      xfer(1, 1'b0, al[k], 8'h00, 1'b0, rd, er, c);
      tests++;
      if (er !== 1'b0) begin
        fails++;
        $display("FAIL rom_rderr_%h: err %b want 0", al[k], er);
      end
      if (model.exists(key(1, al[k]))) begin
        tests++;
        if (rd !== model[key(1, al[k])]) begin
          fails++;
          $display("FAIL rom_rd_%h: data %h want %h",
                   al[k], rd, model[key(1, al[k])]);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] rd; logic er; int c;
    logic [15:0] a;
    for (int n = 0; n <= 65536 / 61 + 1; n++) begin
      a = (n * 61 > 65535) ? 16'hFFFF : 16'(n * 61);
      xfer(0, 1'b1, a, a[7:0], 1'b0, rd, er, c);
      mdl_write(0, a, a[7:0]);
    end
    for (int n = 0; n <= 65536 / 61 + 1; n++) begin
      a = (n * 61 > 65535) ? 16'hFFFF : 16'(n * 61);
      xfer(0, 1'b0, a, 8'h00, 1'b0, rd, er, c);
      if (model.exists(key(0, a))) begin
        tests++;
        if (rd !== model[key(0, a)]) begin
          fails++;
          $display("FAIL sweep_%h: data %h want %h",
                   a, rd, model[key(0, a)]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] rd; logic er; int c; int i;
    logic wr; logic [15:0] a; logic [7:0] d; bit scr;
    logic [15:0] bases [4];
    bases[0] = 16'h0000; bases[1] = 16'h7FF8;
    bases[2] = 16'hFBFC; bases[3] = 16'hFFF8;
    for (int n = 0; n < 300; n++) begin
      i   = int'($urandom_range(0, 2));
      wr  = 1'($urandom);
      a   = bases[$urandom_range(0, 3)] + 16'($urandom_range(0, 7));
      d   = 8'($urandom);
      scr = 1'($urandom);
      xfer(i, wr, a, d, scr, rd, er, c);
      tests++;
      if (c != exp_cyc(i) || er !== exp_err(wr, a)) begin
        fails++;
        $display("FAIL rand_%0d_u%0d_%h: cycles %0d err %b want %0d %b",
                 n, i, a, c, er, exp_cyc(i), exp_err(wr, a));
      end
      if (wr) begin
        mdl_write(i, a, d);
      end else if (model.exists(key(i, a))) begin
        tests++;
        if (rd !== model[key(i, a)]) begin
          fails++;
          $display("FAIL rand_rd_%0d_u%0d_%h: data %h want %h",
                   n, i, a, rd, model[key(i, a)]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_protocol_violation();
    test_reset_mid();
    test_rom();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
